// File: rtl/sipo_word_assembler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sipo_word_assembler_pkg
// Description : Shared FSM state encodings and width helper for the
//               serial-to-parallel word assembler.
// Revision    : 1.0
// ============================================================================
package sipo_word_assembler_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sipo_word_assembler_if.sv
`default_nettype none
// ============================================================================
// Module      : sipo_word_assembler_if
// Description : Serial input and parallel word handshake bundle.
// Revision    : 1.0
// ============================================================================
interface sipo_word_assembler_if #(
    parameter int N = 8
) ();
    logic         sync;
    logic         ser_in;
    logic         ser_valid;
    logic         word_ready;
    logic [N-1:0] word_out;
    logic         word_valid;
    logic         overflow;
    logic         busy;

    modport master (
        output sync, ser_in, ser_valid, word_ready,
        input  word_out, word_valid, overflow, busy
    );

    modport slave (
        input  sync, ser_in, ser_valid, word_ready,
        output word_out, word_valid, overflow, busy
    );
endinterface
`default_nettype wire

// File: rtl/sipo_word_assembler_bit_counter_pc.sv
`default_nettype none
// ============================================================================
// Module      : bit_counter_pc
// Description : Mod-N up counter; sync_clr with inc lands on 1 (first bit).
// Revision    : 1.0
// ============================================================================
module bit_counter_pc #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  wire logic         clk,
    input  wire logic         clear,
    input  wire logic         inc,
    input  wire logic         sync_clr,
    output logic     [W-1:0]  cnt,
    output logic              last
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_cnt <= '0;
        end else if (sync_clr) begin
            r_cnt <= inc ? W'(1) : '0;
        end else if (inc) begin
            r_cnt <= last ? '0 : r_cnt + W'(1);
        end
    end

    assign cnt  = r_cnt;
    assign last = (r_cnt == W'(N - 1));
endmodule
`default_nettype wire

// File: rtl/sipo_word_assembler.sv
`default_nettype none
// ============================================================================
// Module      : sipo_word_assembler
// Description : Double-buffered serial-in parallel-out word assembler.
// Revision    : 1.0
// ============================================================================
module sipo_word_assembler
    import sipo_word_assembler_pkg::*;
#(
    parameter int N         = 8,
    parameter int MSB_FIRST = 1
) (
    input  wire logic              clk,
    input  wire logic              clear,
    sipo_word_assembler_if.slave   bus
);
    localparam int CNT_W = clog2(N);

    logic [1:0]       r_state;
    logic [N-1:0]     r_shifter;
    logic [N-1:0]     r_word_out;
    logic             r_word_valid;
    logic             r_overflow;
    logic [N-1:0]     w_shift;
    logic [N-1:0]     w_first;
    logic [CNT_W-1:0] w_cnt;
    logic             w_last;
    logic             w_inc;
    logic             w_complete;
    logic             w_xfer_ok;

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_shift = {r_shifter[N-2:0], bus.ser_in};
            assign w_first = {{(N-1){1'b0}}, bus.ser_in};
        end else begin : g_lsb_first
            assign w_shift = {bus.ser_in, r_shifter[N-1:1]};
            assign w_first = {bus.ser_in, {(N-1){1'b0}}};
        end
    endgenerate

    // A bit is counted unless it is dropped in FULL with the holding register blocked
    assign w_inc      = bus.ser_valid && (bus.sync || (r_state != ST_FULL) || bus.word_ready);
    assign w_complete = bus.ser_valid && w_last && (r_state != ST_FULL);
    assign w_xfer_ok  = !r_word_valid || bus.word_ready;

    bit_counter_pc #(
        .N (N),
        .W (CNT_W)
    ) u_bit_counter (
        .clk      (clk),
        .clear    (clear),
        .inc      (w_inc),
        .sync_clr (bus.sync),
        .cnt      (w_cnt),
        .last     (w_last)
    );

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state      <= ST_IDLE;
            r_shifter    <= '0;
            r_word_out   <= '0;
            r_word_valid <= 1'b0;
            r_overflow   <= 1'b0;
        end else if (bus.sync) begin
            r_state    <= bus.ser_valid ? ST_SHIFT : ST_IDLE;
            r_shifter  <= bus.ser_valid ? w_first : '0;
            r_overflow <= 1'b0;
            if (bus.word_ready) begin
                r_word_valid <= 1'b0;
            end
        end else begin
            case (r_state)
                ST_IDLE, ST_SHIFT: begin
                    if (bus.ser_valid) begin
                        r_shifter <= w_shift;
                        r_state   <= ST_SHIFT;
                    end
                    if (w_complete) begin
                        if (w_xfer_ok) begin
                            r_word_out   <= w_shift;
                            r_word_valid <= 1'b1;
                            r_state      <= ST_IDLE;
                        end else begin
                            r_state <= ST_FULL;
                        end
                    end else if (bus.word_ready) begin
                        r_word_valid <= 1'b0;
                    end
                end
                ST_FULL: begin
                    // Holding register is always valid here; ready swaps in the parked word
                    if (bus.word_ready) begin
                        r_word_out <= r_shifter;
                        if (bus.ser_valid) begin
                            r_shifter <= w_shift;
                            r_state   <= ST_SHIFT;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else if (bus.ser_valid) begin
                        r_overflow <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // The counter sits at zero exactly when no partial word is being collected
    assert property (@(posedge clk) disable iff (clear)
        (r_state != ST_SHIFT) == (w_cnt == '0));

    assign bus.word_out   = r_word_out;
    assign bus.word_valid = r_word_valid;
    assign bus.overflow   = r_overflow;
    assign bus.busy       = (r_state != ST_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_sipo_word_assembler.sv
`default_nettype none
// ============================================================================
// Module      : tb_sipo_word_assembler
// Description : Bench for both bit orders against a bit-list reference model.
// Revision    : 1.0
// ============================================================================
module tb_sipo_word_assembler;

    typedef struct packed {
        logic       s;
        logic       sv;
        logic       si;
        logic       rdy;
        logic [7:0] em;
        logic [7:0] el;
        logic       ev;
        logic       eo;
        logic       eb;
    } vec_t;

    logic clk        = 1'b0;
    logic clear      = 1'b1;
    logic sync       = 1'b0;
    logic ser_in     = 1'b0;
    logic ser_valid  = 1'b0;
    logic word_ready = 1'b0;

    int checks   = 0;
    int failures = 0;

    vec_t       tbl [9];
    logic [7:0] stream;

    // Reference model, index 0 = MSB-first device, 1 = LSB-first device
    bit         mbits  [2][8];
    int         mlen   [2];
    bit         mpend  [2];
    logic [7:0] mpw    [2];
    logic [7:0] mout   [2];
    bit         mvalid [2];
    bit         movf   [2];

    sipo_word_assembler_if #(.N(8)) bus_m ();
    sipo_word_assembler_if #(.N(8)) bus_l ();

    assign bus_m.sync       = sync;
    assign bus_m.ser_in     = ser_in;
    assign bus_m.ser_valid  = ser_valid;
    assign bus_m.word_ready = word_ready;
    assign bus_l.sync       = sync;
    assign bus_l.ser_in     = ser_in;
    assign bus_l.ser_valid  = ser_valid;
    assign bus_l.word_ready = word_ready;

    sipo_word_assembler #(.N(8), .MSB_FIRST(1)) u_dut_msb (
        .clk   (clk),
        .clear (clear),
        .bus   (bus_m)
    );

    sipo_word_assembler #(.N(8), .MSB_FIRST(0)) u_dut_lsb (
        .clk   (clk),
        .clear (clear),
        .bus   (bus_l)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mlen[k]   = 0;
            mpend[k]  = 1'b0;
            mpw[k]    = 8'h00;
            mout[k]   = 8'h00;
            mvalid[k] = 1'b0;
            movf[k]   = 1'b0;
        end
    endtask

    function automatic logic [7:0] assemble(input int k);
        logic [7:0] w;
        w = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (mbits[k][i]) w = w | (8'h01 << ((k == 0) ? (7 - i) : i));
        end
        return w;
    endfunction

    task automatic model_step(input int k);
        bit xfer;
        xfer = 1'b0;
        if (sync) begin
            mlen[k]  = 0;
            mpend[k] = 1'b0;
            movf[k]  = 1'b0;
            if (ser_valid) begin
                mbits[k][0] = ser_in;
                mlen[k]     = 1;
            end
            if (word_ready) mvalid[k] = 1'b0;
        end else if (mpend[k]) begin
            if (word_ready) begin
                mout[k]   = mpw[k];
                mvalid[k] = 1'b1;
                mpend[k]  = 1'b0;
                if (ser_valid) begin
                    mbits[k][0] = ser_in;
                    mlen[k]     = 1;
                end
            end else if (ser_valid) begin
                movf[k] = 1'b1;
            end
        end else begin
            if (ser_valid) begin
                mbits[k][mlen[k]] = ser_in;
                mlen[k] = mlen[k] + 1;
                if (mlen[k] == 8) begin
                    mlen[k] = 0;
                    if (!mvalid[k] || word_ready) begin
                        mout[k]   = assemble(k);
                        mvalid[k] = 1'b1;
                        xfer      = 1'b1;
                    end else begin
                        mpw[k]   = assemble(k);
                        mpend[k] = 1'b1;
                    end
                end
            end
            if (!xfer && word_ready) mvalid[k] = 1'b0;
        end
    endtask

    task automatic compare_model();
        check("msb.word_out",   bus_m.word_out,   mout[0]);
        check("msb.word_valid", bus_m.word_valid, mvalid[0]);
        check("msb.overflow",   bus_m.overflow,   movf[0]);
        check("msb.busy",       bus_m.busy,       mpend[0] || (mlen[0] != 0));
        check("lsb.word_out",   bus_l.word_out,   mout[1]);
        check("lsb.word_valid", bus_l.word_valid, mvalid[1]);
        check("lsb.overflow",   bus_l.overflow,   movf[1]);
        check("lsb.busy",       bus_l.busy,       mpend[1] || (mlen[1] != 0));
    endtask

    task automatic cyc(input logic s, input logic sv, input logic si, input logic rdy);
        sync       = s;
        ser_valid  = sv;
        ser_in     = si;
        word_ready = rdy;
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        compare_model();
    endtask

    task automatic send_word(input logic [7:0] w, input logic rdy);
        for (int i = 7; i >= 0; i--) cyc(1'b0, 1'b1, w[i], rdy);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".msb.word_out"},   bus_m.word_out,   32'h0);
        check({tag, ".msb.word_valid"}, bus_m.word_valid, 32'h0);
        check({tag, ".msb.overflow"},   bus_m.overflow,   32'h0);
        check({tag, ".msb.busy"},       bus_m.busy,       32'h0);
        check({tag, ".lsb.word_out"},   bus_l.word_out,   32'h0);
        check({tag, ".lsb.word_valid"}, bus_l.word_valid, 32'h0);
    endtask

    initial begin
        model_reset();
        stream = 8'hB2;
        for (int i = 0; i < 8; i++) begin
            tbl[i] = '{1'b0, 1'b1, stream[7-i], 1'b1,
                       (i == 7) ? 8'hB2 : 8'h00, (i == 7) ? 8'h4D : 8'h00,
                       logic'(i == 7), 1'b0, logic'(i != 7)};
        end
        tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hB2, 8'h4D, 1'b0, 1'b0, 1'b0};

        #12;
        check_all_zero("reset");
        clear = 1'b0;

        // Single word in both bit orders
        for (int i = 0; i < 9; i++) begin
            cyc(tbl[i].s, tbl[i].sv, tbl[i].si, tbl[i].rdy);
            check("vec.msb.word_out", bus_m.word_out,   tbl[i].em);
            check("vec.lsb.word_out", bus_l.word_out,   tbl[i].el);
            check("vec.word_valid",   bus_m.word_valid, tbl[i].ev);
            check("vec.overflow",     bus_m.overflow,   tbl[i].eo);
            check("vec.busy",         bus_m.busy,       tbl[i].eb);
        end

        // Backpressure: second word parks in the shifter, extra bits overflow
        send_word(8'hB2, 1'b0);
        check("bp.first_word", bus_m.word_out, 8'hB2);
        send_word(8'h5A, 1'b0);
        check("bp.full_busy", bus_m.busy, 1'b1);
        check("bp.full_hold", bus_m.word_out, 8'hB2);
        check("bp.no_ovf_yet", bus_m.overflow, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        check("bp.ovf_set", bus_m.overflow, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        check("bp.still_hold", bus_m.word_out, 8'hB2);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("bp.release_word", bus_m.word_out, 8'h5A);
        check("bp.release_valid", bus_m.word_valid, 1'b1);
        check("bp.release_idle", bus_m.busy, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("bp.consumed", bus_m.word_valid, 1'b0);
        check("bp.ovf_sticky", bus_m.overflow, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        check("bp.sync_clr_ovf", bus_m.overflow, 1'b0);

        // FULL with ready and a new bit together
        send_word(8'hB2, 1'b0);
        send_word(8'h5A, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        check("full_rs.word_out", bus_m.word_out, 8'h5A);
        check("full_rs.busy", bus_m.busy, 1'b1);
        check("full_rs.overflow", bus_m.overflow, 1'b0);
        stream = 8'hE7;
        for (int i = 6; i >= 0; i--) cyc(1'b0, 1'b1, stream[i], 1'b1);
        check("full_rs.next_word", bus_m.word_out, 8'hE7);
        check("full_rs.next_valid", bus_m.word_valid, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // sync discards a partial word
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        check("sync.idle", bus_m.busy, 1'b0);
        send_word(8'hC3, 1'b1);
        check("sync.word", bus_m.word_out, 8'hC3);
        check("sync.ovf", bus_m.overflow, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        stream = 8'h96;
        cyc(1'b1, 1'b1, stream[7], 1'b1);
        check("sync_sv.busy", bus_m.busy, 1'b1);
        for (int i = 6; i >= 0; i--) cyc(1'b0, 1'b1, stream[i], 1'b1);
        check("sync_sv.word", bus_m.word_out, 8'h96);

        // Asynchronous clear mid-word with a valid word held
        send_word(8'hA5, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        #2;
        clear = 1'b1;
        #1;
        check_all_zero("aclr");
        model_reset();
        #1;
        clear = 1'b0;
        send_word(8'h3C, 1'b1);
        check("aclr.clean_word", bus_m.word_out, 8'h3C);
        check("aclr.clean_valid", bus_m.word_valid, 1'b1);

        // Randomised traffic with alternating backpressure phases
        for (int n = 0; n < 3000; n++) begin
            logic r;
            if (((n / 200) % 2) == 1) r = ($urandom_range(0, 3) == 0);
            else                      r = ($urandom_range(0, 3) != 0);
            cyc(logic'($urandom_range(0, 31) == 0), logic'($urandom_range(0, 3) != 0),
                logic'($urandom_range(0, 1)), r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
